// File: rtl/clkdiv_multi.sv
// clkdiv_multi -- multi-channel programmable clock divider.
//
// Each channel divides clk_in by a run-time divisor and produces a 50%-duty
// registered clock plus a one-cycle tick on every 0->1 transition of that
// clock. A channel's half-period is div_act+1 input cycles. New divisors are
// written through the load/ack port, held as pending, and only copied into
// the active divisor at a half-period boundary (or while the channel is
// disabled), so the output never produces a runt pulse.
//
// Ports:
//   clk_in    in   1         system clock, rising edge
//   rst_n     in   1         asynchronous active-low reset
//   en        in   CHANNELS  per-channel enable (level)
//   load      in   1         one-cycle divisor write request
//   load_ch   in   CH_W      channel targeted by the write
//   load_div  in   WIDTH     divisor value to write
//   load_ack  out  1         one-cycle pulse after an accepted write
//   clk_out   out  CHANNELS  divided clocks (registered)
//   tick      out  CHANNELS  pulse on each 0->1 of clk_out (registered)
module clkdiv_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 200,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic                load_ack,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  // One extra bit so the range check also works when CHANNELS is a power
  // of two (every load_ch value is then in range).
  localparam int              CMP_W    = CH_W + 1;
  localparam logic [CMP_W-1:0] CH_LIMIT = CMP_W'(CHANNELS);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);

  logic load_valid;
  assign load_valid = load && ({1'b0, load_ch} < CH_LIMIT);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      load_ack <= 1'b0;
    end else begin
      load_ack <= load_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] count_reg;
      logic [WIDTH-1:0] div_act_reg;
      logic [WIDTH-1:0] div_pend_reg;
      logic             pend_valid_reg;
      logic             clk_reg;
      logic             tick_reg;
      logic             sel;
      logic             boundary;
      logic             apply;

      assign sel      = load_valid && (load_ch == CH_W'(gi));
      assign boundary = (count_reg == div_act_reg);
      // The pending divisor is consumed at a toggle edge, or on any edge
      // while the channel is disabled (there is no phase to protect then).
      assign apply    = pend_valid_reg && (!en[gi] || boundary);

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          count_reg      <= '0;
          div_act_reg    <= DIV_RST;
          div_pend_reg   <= DIV_RST;
          pend_valid_reg <= 1'b0;
          clk_reg        <= 1'b0;
          tick_reg       <= 1'b0;
        end else begin
          if (en[gi]) begin
            if (boundary) begin
              count_reg <= '0;
              clk_reg   <= ~clk_reg;
              tick_reg  <= ~clk_reg;  // high only when toggling 0->1
            end else begin
              count_reg <= count_reg + WIDTH'(1);
              tick_reg  <= 1'b0;
            end
          end else begin
            count_reg <= '0;
            clk_reg   <= 1'b0;
            tick_reg  <= 1'b0;
          end

          if (apply) begin
            div_act_reg <= div_pend_reg;
          end

          // A write landing on the same edge as a reload overrides the
          // clear, so it stays pending for the following boundary while the
          // older value is the one moved into div_act this edge.
          if (sel) begin
            div_pend_reg   <= load_div;
            pend_valid_reg <= 1'b1;
          end else if (apply) begin
            pend_valid_reg <= 1'b0;
          end
        end
      end

      assign clk_out[gi] = clk_reg;
      assign tick[gi]    = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi, built with 5 channels so that
// load_ch values 5..7 are out of range.
module tb_clkdiv_multi;
  localparam int CHANNELS = 5;
  localparam int WIDTH    = 16;
  localparam int CH_W     = 3;

  logic                clk_in;
  logic                rst_n;
  logic [CHANNELS-1:0] en;
  logic                load;
  logic [CH_W-1:0]     load_ch;
  logic [WIDTH-1:0]    load_div;
  logic                load_ack;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;

  clkdiv_multi #(
    .CHANNELS(CHANNELS),
    .WIDTH(WIDTH),
    .DEFAULT_DIV(200),
    .CH_W(CH_W)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .load_ch(load_ch),
    .load_div(load_div),
    .load_ack(load_ack),
    .clk_out(clk_out),
    .tick(tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [CHANNELS-1:0] prev_out;

  typedef struct {
    int ch;
    int div;
    int half;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: remember outputs, advance to just after the next edge.
  task automatic step();
    prev_out = clk_out;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Step until clk_out[ch] changes; returns the cycle number, or -1.
  task automatic wait_toggle(input int ch, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      step();
      if (clk_out[ch] !== prev_out[ch]) t = cyc;
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL toggle_timeout ch%0d: got none expected a toggle within %0d cycles", ch, budget);
    end
  endtask

  task automatic do_load(input int ch, input int div);
    load     = 1'b1;
    load_ch  = CH_W'(ch);
    load_div = WIDTH'(div);
    step();
    load     = 1'b0;
  endtask

  int t, t1, t2;

  initial begin
    vecs[0] = '{ch: 1, div: 2, half: 3};
    vecs[1] = '{ch: 2, div: 0, half: 1};
    vecs[2] = '{ch: 3, div: 1, half: 2};
    vecs[3] = '{ch: 4, div: 4, half: 5};
    vecs[4] = '{ch: 0, div: 0, half: 1};
    vecs[5] = '{ch: 1, div: 7, half: 8};

    en = '0; load = 1'b0; load_ch = '0; load_div = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(); step();
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_ack", int'(load_ack), 0);

    // Enable everything; all channels run in phase at the default divisor.
    rst_n = 1'b1; en = '1; cyc = 0;
    wait_toggle(0, 500, t);
    check("ch0_first_rise_cycle", t, 201);
    check("all_rise_together", int'(clk_out), 31);
    check("tick_on_rise", int'(tick), 31);
    step();
    check("tick_one_cycle", int'(tick), 0);
    $display("ch0 first rise at cycle %0d", t);

    // ch1: reload mid half-period.
    while (cyc < 250) step();
    do_load(1, 3);
    check("ch1_ack", int'(load_ack), 1);
    step();
    check("ch1_ack_single", int'(load_ack), 0);
    wait_toggle(1, 500, t);
    check("ch1_old_boundary", t, 402);
    wait_toggle(1, 50, t);
    check("ch1_first_new_half", t, 406);
    check("ch1_rise_after_reload", int'(clk_out[1]), 1);
    wait_toggle(0, 500, t);
    check("ch0_phase_kept", t, 603);
    $display("ch1 reload to div=3 done, ch0 rise at %0d", t);

    // ch2: two loads before the boundary, last one wins.
    do_load(2, 0);
    check("ch2_ack_first", int'(load_ack), 1);
    do_load(2, 5);
    check("ch2_ack_second", int'(load_ack), 1);
    step();
    check("ch2_ack_done", int'(load_ack), 0);
    wait_toggle(2, 500, t);
    check("ch2_old_boundary", t, 804);
    wait_toggle(2, 50, t);
    check("ch2_last_load_wins", t, 810);
    $display("ch2 back-to-back loads, toggle at %0d", t);

    // Out-of-range channel: no ack, nothing moves.
    do_load(5, 9);
    check("oor_no_ack", int'(load_ack), 0);
    wait_toggle(2, 50, t);
    check("oor_ch2_unchanged", t, 816);
    wait_toggle(1, 50, t);
    check("oor_ch1_unchanged", t, 818);
    $display("out-of-range load ignored");

    // ch3: disable while high, then re-enable.
    wait_toggle(3, 500, t);
    check("ch3_rise", t, 1005);
    check("ch3_high", int'(clk_out[3]), 1);
    en[3] = 1'b0;
    step();
    check("ch3_low_after_disable", int'(clk_out[3]), 0);
    check("ch3_tick_low_disabled", int'(tick[3]), 0);
    while (cyc < 1010) step();
    en[3] = 1'b1;
    wait_toggle(3, 500, t);
    check("ch3_reenable_rise", t, 1211);
    check("ch3_reenable_tick", int'(tick[3]), 1);
    $display("ch3 re-enable rise at %0d", t);

    // Table: steady half-period after a reload.
    foreach (vecs[i]) begin
      do_load(vecs[i].ch, vecs[i].div);
      check("tbl_ack", int'(load_ack), 1);
      wait_toggle(vecs[i].ch, 1000, t);
      wait_toggle(vecs[i].ch, 1000, t1);
      wait_toggle(vecs[i].ch, 1000, t2);
      check("tbl_half_period", t2 - t1, vecs[i].half);
      check("tbl_tick_matches_rise", int'(tick[vecs[i].ch]), int'(clk_out[vecs[i].ch]));
      $display("vec %0d ch%0d div=%0d half=%0d", i, vecs[i].ch, vecs[i].div, t2 - t1);
    end

    // Async reset with a pending load on ch4.
    do_load(4, 30);
    wait_toggle(4, 100, t);
    wait_toggle(4, 100, t);
    do_load(4, 9);
    check("pre_reset_ack", int'(load_ack), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clk_out", int'(clk_out), 0);
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_ack", int'(load_ack), 0);
    step(); step();
    rst_n = 1'b1; cyc = 0;
    wait_toggle(4, 500, t);
    check("post_reset_default", t, 201);
    check("post_reset_all_high", int'(clk_out), 31);
    wait_toggle(4, 500, t);
    check("post_reset_pending_lost", t, 402);
    $display("reset recovery, ch4 toggle at %0d", t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel programmable clock divider. It is the next generation of the team's single-channel fixed divider. Each of CHANNELS independent channels divides clk_in by a run-time divisor, produces a 50%-duty divided clock and a one-cycle rising-edge tick, and can be enabled individually. Divisors are reloaded through a load/ack port and take effect only at a half-period boundary, so no runt pulses are produced. The block sits between the board clock and the slow-logic consumers: display scan, debouncers and blink timers.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 16: divisor and counter width in bits.
- DEFAULT_DIV, 200: divisor loaded into every channel at reset; must fit in WIDTH.
- CH_W, $clog2(CHANNELS) with a minimum of 1: width of the channel select.

Ports:
- clk_in  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel enable, level-sensitive.
- load  in  1  one-cycle request to write a divisor.
- load_ch  in  CH_W  target channel of the load.
- load_div  in  WIDTH  new divisor value.
- load_ack  out  1  one-cycle pulse confirming an accepted load.
- clk_out  out  CHANNELS  divided clocks (registered).
- tick  out  CHANNELS  one-cycle pulse on each 0->1 transition of clk_out (registered).

## Operation
- Per-channel state: count[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend_valid, clk_out bit, tick bit.
- Reset (rst_n low, asynchronous):
  - count = 0, clk_out = 0, tick = 0, load_ack = 0.
  - div_act = DEFAULT_DIV, pend_valid = 0.
  - Takes effect immediately, including mid-period or mid-load; any pending load is discarded.
- Enabled channel, on each clock:
  - If count == div_act: clk_out toggles and count returns to 0.
  - Otherwise count increments by 1.
  - Each half-period is therefore div_act+1 cycles, and the full period is 2*(div_act+1) cycles.
  - div_act = 0 gives clk_in/2.
- tick is 1 exactly on the cycle after the edge where clk_out goes 0->1, and 0 otherwise.
- Load handling:
  - A load with load_ch < CHANNELS is accepted: div_pend[load_ch] = load_div, pend_valid = 1.
  - load_ack pulses high one cycle later.
  - A load with load_ch >= CHANNELS is ignored and produces no ack.
- Reload point:
  - On an enabled channel, a pending divisor moves to div_act at the first edge where count == div_act, i.e. at the same edge as the toggle; pend_valid then clears.
  - The new half-period starts immediately after that edge.
- Back-to-back loads to the same channel before the reload point: the last one wins, and each load is acked.
- A load arriving on the same edge as the reload point is not applied at that boundary. It becomes pending for the next boundary, and the old pending value is applied.
- Disabled channel (en bit low):
  - On the next edge: count = 0, clk_out = 0, tick = 0.
  - A pending divisor is applied to div_act on that edge; a load accepted while disabled is applied on the following edge.
- Re-enable: counting starts from count = 0 with clk_out = 0. The first 0->1 toggle happens after div_act+1 enabled cycles.
- Arithmetic: unsigned, WIDTH bits. count never exceeds div_act, so there is no wrap.
- Channels are fully independent. A load to one channel never disturbs the phase of another.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- load -> load_ack: 1 cycle.
- Divisor-change latency: at most one current half-period, i.e. div_act+1 cycles.
- en falling -> clk_out low: 1 cycle.
- Single clock domain. Consumers that use clk_out as a clock are responsible for their own buffering; synchronous consumers are expected to use tick.

## Test plan
- Reset then enable ch0 with DEFAULT_DIV=200 -> clk_out[0] rises after 201 cycles and has period 402 cycles; tick[0] is a single-cycle pulse every 402 cycles.
- Load div=3 to ch1 mid half-period -> load_ack high one cycle later; the current half-period completes at the old length, then half-periods are 4 cycles with no runt; ch0 phase is unchanged.
- Load div=0 to ch2, then load div=5 before the boundary -> only div=5 takes effect, with 6-cycle half-periods; two acks are observed.
- Load with load_ch=CHANNELS (out of range, CHANNELS non-power-of-2 build) -> no ack and no channel changes.
- Drop en[3] while clk_out[3] is high -> clk_out[3] is 0 on the next edge and count resets; re-enable -> first rise after div_act+1 cycles.
- Assert rst_n low mid-period with a load pending -> all outputs are 0 immediately; after release every channel runs at DEFAULT_DIV and the pending value is lost.
